// File: rtl/pc_control.sv
// Next-PC selection: PC+2, PC-relative immediate branch, or register branch,
// with a combinational hold on HLT and a sticky registered halted flag.
module pc_control (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  C,
   input  logic [8:0]  I,
   input  logic [2:0]  F,
   input  logic [15:0] PC_control_in,
   input  logic [15:0] reg2_data,
   input  logic        branch_type,
   input  logic        halt,
   input  logic        branch_ins,
   output logic [15:0] PC_control_out,
   output logic        branch_taken,
   output logic        halted
);

   logic        flag_n;
   logic        flag_v;
   logic        flag_z;
   logic        cond_met;
   logic [15:0] pc_plus2;
   logic [15:0] imm_offset;
   logic [15:0] imm_target;
   logic        halted_reg;

   assign flag_n = F[2];
   assign flag_v = F[1];
   assign flag_z = F[0];

   always_comb begin
      cond_met = 1'b0;
      case (C)
         3'b000:  cond_met = ~flag_z;
         3'b001:  cond_met = flag_z;
         3'b010:  cond_met = ~flag_z & ~flag_n;
         3'b011:  cond_met = flag_n;
         3'b100:  cond_met = flag_z | (~flag_z & ~flag_n);
         3'b101:  cond_met = flag_n | flag_z;
         3'b110:  cond_met = flag_v;
         default: cond_met = 1'b1;
      endcase
   end

   // Offset is in instruction words, so sign-extend and scale to bytes.
   assign pc_plus2   = PC_control_in + 16'd2;
   assign imm_offset = {{6{I[8]}}, I, 1'b0};
   assign imm_target = pc_plus2 + imm_offset;

   assign branch_taken = branch_ins & cond_met & ~halt;

   // Deliberately independent of halted_reg so the PC is valid before reset.
   always_comb begin
      PC_control_out = pc_plus2;
      if (halt)
         PC_control_out = PC_control_in;
      else if (branch_ins & cond_met)
         PC_control_out = branch_type ? reg2_data : imm_target;
   end

   always_ff @(posedge clk) begin
      if (rst)
         halted_reg <= 1'b0;
      else if (halt)
         halted_reg <= 1'b1;
   end

   assign halted = halted_reg;

endmodule

// File: tb/tb_pc_control.sv
// Directed-vector bench for pc_control: next-PC selection, branch conditions,
// wrap-around and the sticky halted flag.
module tb_pc_control;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  C;
   logic [8:0]  I;
   logic [2:0]  F;
   logic [15:0] PC_control_in;
   logic [15:0] reg2_data;
   logic        branch_type;
   logic        halt;
   logic        branch_ins;
   logic [15:0] PC_control_out;
   logic        branch_taken;
   logic        halted;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pc_control dut (
      .clk            (clk),
      .rst            (rst),
      .C              (C),
      .I              (I),
      .F              (F),
      .PC_control_in  (PC_control_in),
      .reg2_data      (reg2_data),
      .branch_type    (branch_type),
      .halt           (halt),
      .branch_ins     (branch_ins),
      .PC_control_out (PC_control_out),
      .branch_taken   (branch_taken),
      .halted         (halted)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, expv);
      end else begin
         $display("ok   %s: 0x%04h", tag, obs);
      end
   endtask

   task automatic drive(input logic bi, input logic h, input logic bt, input logic [2:0] c,
                        input logic [2:0] f, input logic [8:0] i, input logic [15:0] pc,
                        input logic [15:0] r2);
      branch_ins = bi; halt = h; branch_type = bt; C = c; F = f; I = i;
      PC_control_in = pc; reg2_data = r2;
      #1;
   endtask

   task automatic check_vec(input string tag, input logic [15:0] exp_pc, input logic exp_taken);
      check({tag, ".pc"}, PC_control_out, exp_pc);
      check({tag, ".taken"}, {15'd0, branch_taken}, {15'd0, exp_taken});
   endtask

   // Condition sweep at PC=0x20, I=4: taken -> 0x2A, not taken -> 0x22.
   task automatic cond(input string tag, input logic [2:0] c, input logic [2:0] f, input logic tk);
      drive(1'b1, 1'b0, 1'b0, c, f, 9'd4, 16'h0020, 16'h0000);
      check_vec(tag, tk ? 16'h002A : 16'h0022, tk);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 9'd10, 16'd10, 16'd0);
      @(posedge clk); #1;
      check("reset.halted", {15'd0, halted}, 16'd0);
      rst = 1'b0;

      drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 9'd10, 16'd10, 16'd0);
      check_vec("seq", 16'd12, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 3'b111, 3'b000, 9'd10, 16'd10, 16'd1000);
      check_vec("nobranch_uncond", 16'd12, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 3'b111, 3'b001, 9'h1FE, 16'd10, 16'd0);
      check_vec("imm_neg", 16'd8, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 9'd3, 16'h0100, 16'd0);
      check_vec("imm_pos", 16'h0108, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 9'h100, 16'h1000, 16'd0);
      check_vec("imm_min", 16'h0E02, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 9'h0FF, 16'h1000, 16'd0);
      check_vec("imm_max", 16'h1200, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 3'b111, 3'b000, 9'd0, 16'd10, 16'd1000);
      check_vec("reg_branch", 16'd1000, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 3'b001, 3'b000, 9'd0, 16'd10, 16'd1000);
      check_vec("reg_not_taken", 16'd12, 1'b0);

      cond("ne_t",  3'b000, 3'b000, 1'b1);
      cond("ne_n",  3'b000, 3'b001, 1'b0);
      cond("eq_t",  3'b001, 3'b001, 1'b1);
      cond("eq_n",  3'b001, 3'b000, 1'b0);
      cond("gt_t",  3'b010, 3'b000, 1'b1);
      cond("gt_n",  3'b010, 3'b100, 1'b0);
      cond("lt_t",  3'b011, 3'b100, 1'b1);
      cond("lt_n",  3'b011, 3'b000, 1'b0);
      cond("gte_t", 3'b100, 3'b001, 1'b1);
      cond("gte_n", 3'b100, 3'b100, 1'b0);
      cond("lte_t", 3'b101, 3'b100, 1'b1);
      cond("lte_n", 3'b101, 3'b000, 1'b0);
      cond("ov_t",  3'b110, 3'b010, 1'b1);
      cond("ov_n",  3'b110, 3'b000, 1'b0);
      cond("un_t",  3'b111, 3'b000, 1'b1);

      drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 9'd0, 16'hFFFE, 16'd0);
      check_vec("wrap_seq", 16'h0000, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 9'h1FF, 16'h0000, 16'd0);
      check_vec("wrap_imm", 16'h0000, 1'b1);

      // Halt: PC holds combinationally, flag sets on the next edge and sticks.
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 3'b111, 3'b000, 9'd0, 16'd100, 16'd1000);
      check_vec("halt_hold", 16'd100, 1'b0);
      check("halted_before_edge", {15'd0, halted}, 16'd0);
      @(posedge clk); #1;
      check("halted_set", {15'd0, halted}, 16'd1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 9'd0, 16'd10, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      check("halted_sticky", {15'd0, halted}, 16'd1);
      check_vec("pc_after_halt", 16'd12, 1'b0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("halted_cleared", {15'd0, halted}, 16'd0);
      @(negedge clk); halt = 1'b1;
      @(posedge clk); #1;
      check("rst_over_halt", {15'd0, halted}, 16'd0);
      @(negedge clk); rst = 1'b0; halt = 1'b0;
      @(posedge clk); #1;
      check("halted_stays_clear", {15'd0, halted}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
